// File: rtl/cpc_mem_sched.sv
// Shared-memory slot scheduler: interleaves video word fetches and CPU
// accesses on one byte-wide memory port, four slots per 1 MHz cycle.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   ce_4p               4 MHz tick enable; the slot sequencer advances on ticks only
//   no_wait             turbo: no CPU wait states, CPU pre-empts any slot
//   cpu_*               CPU request side (level MREQ/IORQ, address, data), cpu_din read data
//   wait_n              CPU wait, active-low (combinational assert on detection)
//   cyc1MHz             high while in the idle slot (phase 3)
//   vid_addr/vid_data   video word address in, fetched word out, vid_valid strobe
//   mem_*               shared memory port, data valid at the end of the slot
module cpc_mem_sched #(
    parameter logic [22:0] VBASE = 23'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_4p,
    input  logic        no_wait,
    input  logic        cpu_mreq,
    input  logic        cpu_iorq,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        wait_n,
    output logic        cyc1MHz,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr
);

    localparam int unsigned AW = 23;
    localparam int unsigned VW = 15;

    typedef enum logic [1:0] {
        PH_VLO  = 2'd0,
        PH_VHI  = 2'd1,
        PH_CPU  = 2'd2,
        PH_IDLE = 2'd3
    } phase_e;

    phase_e          phase, phase_nx;
    logic            acc_q, pending, io_q, wr_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      dout_q;
    logic [VW-1:0]   vaddr_q;
    logic [7:0]      lo_q;
    logic            cpu_slot;   // current slot is a CPU memory cycle
    logic            vid_lost;   // current video frame lost a slot (or is the post-reset partial frame)

    logic            acc_c, new_c, det_c, req_mem_c, serve_c, io_done_c;
    logic            sel_wr_c;
    logic [AW-1:0]   sel_addr_c;
    logic [7:0]      sel_dout_c;

    // Next phase, request detection and slot arbitration
    always_comb begin
        phase_nx   = phase_e'(2'(phase + 2'd1));
        acc_c      = cpu_mreq | cpu_iorq;
        new_c      = reset_n & acc_c & ~acc_q & ~pending;
        det_c      = ce_4p & new_c;
        // a request detected on this tick may be served in the slot it opens
        sel_addr_c = pending ? addr_q : cpu_addr;
        sel_dout_c = pending ? dout_q : cpu_dout;
        sel_wr_c   = pending ? wr_q   : cpu_wr;
        req_mem_c  = (pending & ~io_q & ~cpu_slot) | (det_c & ~cpu_iorq);
        serve_c    = ce_4p & req_mem_c & ((phase_nx == PH_CPU) | no_wait);
        io_done_c  = ce_4p & pending & io_q & (no_wait | (phase == PH_IDLE));
        wait_n     = no_wait | ~(pending | new_c);
    end

    // Slot sequencer and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= PH_VLO;
            cyc1MHz   <= 1'b0;
            acc_q     <= 1'b0;
            pending   <= 1'b0;
            io_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            vaddr_q   <= '0;
            lo_q      <= '0;
            cpu_slot  <= 1'b0;
            vid_lost  <= 1'b1;
            cpu_din   <= 8'hFF;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            mem_addr  <= '0;
            mem_dout  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            vid_valid <= 1'b0;
            if (ce_4p) begin
                phase   <= phase_nx;
                cyc1MHz <= (phase_nx == PH_IDLE);
                acc_q   <= acc_c;

                if (det_c) begin
                    pending <= 1'b1;
                    addr_q  <= cpu_addr;
                    dout_q  <= cpu_dout;
                    wr_q    <= cpu_wr;
                    io_q    <= cpu_iorq;
                end

                // close the slot that is ending on this tick
                if (cpu_slot) begin
                    pending <= 1'b0;
                    if (!wr_q) begin
                        cpu_din <= mem_din;
                    end
                end else if ((phase == PH_VLO) && mem_rd) begin
                    lo_q <= mem_din;
                end else if ((phase == PH_VHI) && mem_rd && !vid_lost) begin
                    vid_data  <= {mem_din, lo_q};
                    vid_valid <= 1'b1;
                end
                if (io_done_c) begin
                    pending <= 1'b0;
                end

                // open the next slot
                mem_rd   <= 1'b0;
                mem_wr   <= 1'b0;
                mem_dout <= '0;
                cpu_slot <= 1'b0;
                if (phase_nx == PH_VLO) begin
                    vaddr_q  <= vid_addr;
                    vid_lost <= 1'b0;
                end
                if (serve_c) begin
                    cpu_slot <= 1'b1;
                    mem_addr <= sel_addr_c;
                    mem_rd   <= ~sel_wr_c;
                    mem_wr   <= sel_wr_c;
                    mem_dout <= sel_wr_c ? sel_dout_c : 8'h00;
                    if ((phase_nx == PH_VLO) || (phase_nx == PH_VHI)) begin
                        vid_lost <= 1'b1;
                    end
                end else if (phase_nx == PH_VLO) begin
                    mem_addr <= VBASE + AW'({vid_addr, 1'b0});
                    mem_rd   <= 1'b1;
                end else if (phase_nx == PH_VHI) begin
                    mem_addr <= VBASE + AW'({vaddr_q, 1'b1});
                    mem_rd   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpc_mem_sched.sv
// Directed bench for cpc_mem_sched: a per-tick vector table covering video
// free-run, CPU read/write, I/O and turbo pre-emption, plus reset sequences.
module tb_cpc_mem_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_4p;
    logic        no_wait;
    logic        cpu_mreq, cpu_iorq, cpu_wr;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        wait_n;
    logic        cyc1MHz;
    logic [14:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic [22:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_rd, mem_wr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpc_mem_sched dut (
        .clk(clk), .reset_n(reset_n), .ce_4p(ce_4p), .no_wait(no_wait),
        .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .wait_n(wait_n), .cyc1MHz(cyc1MHz), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_valid(vid_valid), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    // Memory model: data for the slot address is available by the end of the slot
    function automatic logic [7:0] mem_model(input logic [22:0] a);
        if (a == 23'h004000) return 8'hA5;
        return 8'(a[7:0] + 8'h11);
    endfunction
    assign mem_din = mem_model(mem_addr);

    typedef struct {
        logic        mreq, iorq, wr, nw;
        logic [22:0] addr;
        logic [7:0]  dout;
        logic        w_pre, w, c, r, mw;
        logic [22:0] ma;
        logic [7:0]  md;
        logic        vv;
        logic [7:0]  din;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic mreq, iorq, wr, nw,
                                input logic [22:0] addr, input logic [7:0] dout,
                                input logic w_pre, w, c, r, mw,
                                input logic [22:0] ma, input logic [7:0] md,
                                input logic vv, input logic [7:0] din);
        vec_t v;
        v.mreq = mreq; v.iorq = iorq; v.wr = wr; v.nw = nw; v.addr = addr; v.dout = dout;
        v.w_pre = w_pre; v.w = w; v.c = c; v.r = r; v.mw = mw; v.ma = ma; v.md = md;
        v.vv = vv; v.din = din;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ce_4p = 1'b1;
        @(posedge clk);
        #1;
        ce_4p = 1'b0;
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_wait_n", idx, 32'(wait_n), 32'd1);
        chk("rst_cyc", idx, 32'(cyc1MHz), 32'd0);
        chk("rst_cpu_din", idx, 32'(cpu_din), 32'hFF);
        chk("rst_vid_data", idx, 32'(vid_data), 32'd0);
        chk("rst_vid_valid", idx, 32'(vid_valid), 32'd0);
        chk("rst_mem_rd", idx, 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", idx, 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", idx, 32'(mem_addr), 32'd0);
        chk("rst_mem_dout", idx, 32'(mem_dout), 32'd0);
    endtask

    initial begin
        // mreq iorq wr nw addr dout | w_pre w cyc rd wr maddr mdout vv din   (ticks from reset)
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h000001, 8'h00, 0, 8'hFF)); // 1
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,0,0, 23'h0,      8'h00, 0, 8'hFF)); // 2 partial frame
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,1,0,0, 23'h0,      8'h00, 0, 8'hFF)); // 3
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002468, 8'h00, 0, 8'hFF)); // 4
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002469, 8'h00, 0, 8'hFF)); // 5
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,0,0, 23'h0,      8'h00, 1, 8'hFF)); // 6
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,1,0,0, 23'h0,      8'h00, 0, 8'hFF)); // 7
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002468, 8'h00, 0, 8'hFF)); // 8
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002469, 8'h00, 0, 8'hFF)); // 9
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,0,0, 23'h0,      8'h00, 1, 8'hFF)); // 10
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,1,0,0, 23'h0,      8'h00, 0, 8'hFF)); // 11
        // CPU read detected at phase 3
        vecs.push_back(mk(1,0,0,0, 23'h004000, 8'h00, 0,0,0,1,0, 23'h002468, 8'h00, 0, 8'hFF)); // 12
        vecs.push_back(mk(1,0,0,0, 23'h004000, 8'h00, 0,0,0,1,0, 23'h002469, 8'h00, 0, 8'hFF)); // 13
        vecs.push_back(mk(1,0,0,0, 23'h004000, 8'h00, 0,0,0,1,0, 23'h004000, 8'h00, 1, 8'hFF)); // 14
        vecs.push_back(mk(1,0,0,0, 23'h004000, 8'h00, 0,1,1,0,0, 23'h0,      8'h00, 0, 8'hA5)); // 15
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002468, 8'h00, 0, 8'hA5)); // 16
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002469, 8'h00, 0, 8'hA5)); // 17
        // CPU write detected entering phase 2
        vecs.push_back(mk(1,0,1,0, 23'h010000, 8'h5A, 0,0,0,0,1, 23'h010000, 8'h5A, 1, 8'hA5)); // 18
        vecs.push_back(mk(1,0,1,0, 23'h010000, 8'h5A, 0,1,1,0,0, 23'h0,      8'h00, 0, 8'hA5)); // 19
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002468, 8'h00, 0, 8'hA5)); // 20
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002469, 8'h00, 0, 8'hA5)); // 21
        // I/O detected at phase 1, completes at end of phase 3
        vecs.push_back(mk(0,1,0,0, 23'h000012, 8'h00, 0,0,0,0,0, 23'h0, 8'h00, 1, 8'hA5)); // 22
        vecs.push_back(mk(0,1,0,0, 23'h000012, 8'h00, 0,0,1,0,0, 23'h0, 8'h00, 0, 8'hA5)); // 23
        vecs.push_back(mk(0,1,0,0, 23'h000012, 8'h00, 0,1,0,1,0, 23'h002468, 8'h00, 0, 8'hA5)); // 24
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002469, 8'h00, 0, 8'hA5)); // 25
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,0,0, 23'h0,      8'h00, 1, 8'hA5)); // 26
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,1,0,0, 23'h0,      8'h00, 0, 8'hA5)); // 27
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002468, 8'h00, 0, 8'hA5)); // 28
        // Turbo read detected at phase 0 pre-empts the video high byte
        vecs.push_back(mk(1,0,0,1, 23'h000155, 8'h00, 1,1,0,1,0, 23'h000155, 8'h00, 0, 8'hA5)); // 29
        vecs.push_back(mk(1,0,0,1, 23'h000155, 8'h00, 1,1,0,0,0, 23'h0,      8'h00, 0, 8'h66)); // 30
        vecs.push_back(mk(1,0,0,1, 23'h000155, 8'h00, 1,1,1,0,0, 23'h0,      8'h00, 0, 8'h66)); // 31
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002468, 8'h00, 0, 8'h66)); // 32
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,1,0, 23'h002469, 8'h00, 0, 8'h66)); // 33
        vecs.push_back(mk(0,0,0,0, 23'h0, 8'h00, 1,1,0,0,0, 23'h0,      8'h00, 1, 8'h66)); // 34

        reset_n = 1'b0; ce_4p = 1'b0; no_wait = 1'b0;
        cpu_mreq = 1'b0; cpu_iorq = 1'b0; cpu_wr = 1'b0;
        cpu_addr = '0; cpu_dout = '0; vid_addr = 15'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        @(negedge clk);
        reset_n = 1'b1;
        // clocks without ce_4p must not move the sequencer
        repeat (4) @(posedge clk);
        #1;
        chk("gate_cyc", 0, 32'(cyc1MHz), 32'd0);
        chk("gate_mem_rd", 0, 32'(mem_rd), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cpu_mreq = vecs[i].mreq; cpu_iorq = vecs[i].iorq; cpu_wr = vecs[i].wr;
            no_wait = vecs[i].nw; cpu_addr = vecs[i].addr; cpu_dout = vecs[i].dout;
            #1;
            chk("wait_n_pre", i + 1, 32'(wait_n), 32'(vecs[i].w_pre));
            tick();
            chk("wait_n", i + 1, 32'(wait_n), 32'(vecs[i].w));
            chk("cyc1MHz", i + 1, 32'(cyc1MHz), 32'(vecs[i].c));
            chk("mem_rd", i + 1, 32'(mem_rd), 32'(vecs[i].r));
            chk("mem_wr", i + 1, 32'(mem_wr), 32'(vecs[i].mw));
            chk("mem_dout", i + 1, 32'(mem_dout), 32'(vecs[i].md));
            chk("vid_valid", i + 1, 32'(vid_valid), 32'(vecs[i].vv));
            chk("cpu_din", i + 1, 32'(cpu_din), 32'(vecs[i].din));
            if (vecs[i].r || vecs[i].mw)
                chk("mem_addr", i + 1, 32'(mem_addr), 32'(vecs[i].ma));
            if (vecs[i].vv) begin
                chk("vid_data", i + 1, 32'(vid_data), 32'h7A79);
                @(posedge clk);
                #1;
                chk("vid_valid_strobe", i + 1, 32'(vid_valid), 32'd0);
            end
        end

        // Reset during a pending write: immediate reset values, write never issued
        @(negedge clk);
        cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 23'h010000; cpu_dout = 8'h5A;
        tick();
        chk("pend_wait_n", 35, 32'(wait_n), 32'd0);
        chk("pend_mem_wr", 35, 32'(mem_wr), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        #1;
        chk_reset(36);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_cyc", 37, 32'(cyc1MHz), 32'd0);
        chk("post_rst_rd", 37, 32'(mem_rd), 32'd1);
        chk("post_rst_addr", 37, 32'(mem_addr), 32'h000001);
        chk("post_rst_wr", 37, 32'(mem_wr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_wr", 38 + k, 32'(mem_wr), 32'd0);
            chk("post_rst_wait_n", 38 + k, 32'(wait_n), 32'd1);
        end
        chk("post_rst_cyc3", 40, 32'(cyc1MHz), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
